// File: rtl/data_memory_bank.sv
// data_memory_bank: parametrised data store with one byte-masked write port,
// two registered read ports with write-first forwarding, and a hardware
// zero-fill sequencer that sweeps the array after reset or on a clear request.
module data_memory_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  output logic                ready,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic                ra_en,
  input  logic [ADDR_W-1:0]   ra_addr,
  output logic [DATA_W-1:0]   ra_data,
  output logic                ra_valid,
  input  logic                rb_en,
  input  logic [ADDR_W-1:0]   rb_addr,
  output logic [DATA_W-1:0]   rb_data,
  output logic                rb_valid
);

  localparam int BYTES = DATA_W / 8;
  // Index width that exactly covers the array; addresses are range-checked
  // before they are truncated to this width.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_next;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              run_ok;
  logic              w_in;
  logic              wr_ok;
  logic              a_in;
  logic              b_in;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  a_idx;
  logic [IDX_W-1:0]  b_idx;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] a_word;
  logic [DATA_W-1:0] b_word;

  // Replace the bytes of old_word selected by mask with the matching bytes
  // of new_word; shared by the write path and both forwarding paths.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BYTES-1:0]  mask
  );
    logic [DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (mask[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return result;
  endfunction

  // Accesses are only honoured in RUN and never in a cycle that starts a
  // clear sweep; out-of-range addresses never touch the array.
  assign run_ok = (state == RUN) && !clear;
  assign w_in   = ({1'b0, waddr} < LIMIT);
  assign a_in   = ({1'b0, ra_addr} < LIMIT);
  assign b_in   = ({1'b0, rb_addr} < LIMIT);
  assign wr_ok  = run_ok && we && w_in;

  assign w_idx  = waddr[IDX_W-1:0];
  assign a_idx  = ra_addr[IDX_W-1:0];
  assign b_idx  = rb_addr[IDX_W-1:0];
  assign c_idx  = count[IDX_W-1:0];

  assign ready  = (state == RUN);

  // State and sweep counter register; reset always restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic: INIT walks the counter to DEPTH-1, RUN waits for clear.
  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      INIT: begin
        if (count == LAST) begin
          state_next = RUN;
          count_next = '0;
        end else begin
          count_next = count + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_next = INIT;
          count_next = '0;
        end
      end
      default: begin
        state_next = INIT;
        count_next = '0;
      end
    endcase
  end

  // Masked write is done as read-modify-write of the whole word.
  always_comb begin
    wr_word = '0;
    if (wr_ok) begin
      wr_word = merge_bytes(mem[w_idx], wdata, wmask);
    end
  end

  // Array update: zero-fill one word per cycle in INIT, masked write in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[c_idx] <= '0;
      end else if (wr_ok) begin
        mem[w_idx] <= wr_word;
      end
    end
  end

  // Port A read word, with the same-cycle write forwarded into it.
  always_comb begin
    a_word = '0;
    if (a_in) begin
      a_word = mem[a_idx];
      if (wr_ok && (waddr == ra_addr)) begin
        a_word = merge_bytes(a_word, wdata, wmask);
      end
    end
  end

  // Port B read word, identical to port A.
  always_comb begin
    b_word = '0;
    if (b_in) begin
      b_word = mem[b_idx];
      if (wr_ok && (waddr == rb_addr)) begin
        b_word = merge_bytes(b_word, wdata, wmask);
      end
    end
  end

  // Port A output register: data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_data  <= '0;
      ra_valid <= 1'b0;
    end else begin
      ra_valid <= run_ok && ra_en;
      if (run_ok && ra_en) begin
        ra_data <= a_word;
      end
    end
  end

  // Port B output register: data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= run_ok && rb_en;
      if (run_ok && rb_en) begin
        rb_data <= b_word;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bank.sv
// tb_data_memory_bank: directed scoreboard bench for data_memory_bank, with a
// default-parameter instance and a DATA_W=32/ADDR_W=4/DEPTH=12 variant.
module tb_data_memory_bank;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int DP  = 32;
  localparam int VDW = 32;
  localparam int VAW = 4;
  localparam int VDP = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, clear, ready, we;
  logic [AW-1:0]   waddr, ra_addr, rb_addr;
  logic [DW-1:0]   wdata, ra_data, rb_data;
  logic [DW/8-1:0] wmask;
  logic            ra_en, rb_en, ra_valid, rb_valid;

  logic             v_rst, v_clear, v_ready, v_we;
  logic [VAW-1:0]   v_waddr, v_ra_addr, v_rb_addr;
  logic [VDW-1:0]   v_wdata, v_ra_data, v_rb_data;
  logic [VDW/8-1:0] v_wmask;
  logic             v_ra_en, v_rb_en, v_ra_valid, v_rb_valid;

  data_memory_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .ra_en(ra_en), .ra_addr(ra_addr), .ra_data(ra_data), .ra_valid(ra_valid),
    .rb_en(rb_en), .rb_addr(rb_addr), .rb_data(rb_data), .rb_valid(rb_valid)
  );

  data_memory_bank #(.DATA_W(VDW), .ADDR_W(VAW), .DEPTH(VDP)) dut_v (
    .clk(clk), .rst(v_rst), .clear(v_clear), .ready(v_ready),
    .we(v_we), .waddr(v_waddr), .wdata(v_wdata), .wmask(v_wmask),
    .ra_en(v_ra_en), .ra_addr(v_ra_addr), .ra_data(v_ra_data), .ra_valid(v_ra_valid),
    .rb_en(v_rb_en), .rb_addr(v_rb_addr), .rb_data(v_rb_data), .rb_valid(v_rb_valid)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qv[$];

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model [0:DP-1];
  logic [DW-1:0] held_a, held_b;
  logic          run_mode;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference prediction for one read port in the cycle being driven.
  function automatic exp_t predictRead(input logic en, input logic [AW-1:0] addr,
                                       input logic iwe, input logic [AW-1:0] iwaddr,
                                       input logic [DW-1:0] iwdata,
                                       input logic [DW/8-1:0] iwmask,
                                       input logic iclear, input logic [DW-1:0] held);
    exp_t e;
    logic [DW-1:0] word;
    e.valid = 1'b0;
    e.data  = {16'h0000, held};
    if (run_mode && !iclear && en) begin
      word = model[addr];
      if (iwe && (iwaddr == addr)) begin
        for (int i = 0; i < DW / 8; i++) begin
          if (iwmask[i]) word[8*i +: 8] = iwdata[8*i +: 8];
        end
      end
      e.valid = 1'b1;
      e.data  = {16'h0000, word};
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic iwe, input logic [AW-1:0] iwaddr,
                               input logic [DW-1:0] iwdata, input logic [DW/8-1:0] iwmask,
                               input logic ira_en, input logic [AW-1:0] ira_addr,
                               input logic irb_en, input logic [AW-1:0] irb_addr,
                               input logic iclear);
    exp_t ea, eb, got;
    we = iwe; waddr = iwaddr; wdata = iwdata; wmask = iwmask;
    ra_en = ira_en; ra_addr = ira_addr; rb_en = irb_en; rb_addr = irb_addr;
    clear = iclear;
    ea = predictRead(ira_en, ira_addr, iwe, iwaddr, iwdata, iwmask, iclear, held_a);
    eb = predictRead(irb_en, irb_addr, iwe, iwaddr, iwdata, iwmask, iclear, held_b);
    held_a = ea.data[DW-1:0];
    held_b = eb.data[DW-1:0];
    qa.push_back(ea);
    qb.push_back(eb);
    if (run_mode && !iclear && iwe) begin
      for (int i = 0; i < DW / 8; i++) begin
        if (iwmask[i]) model[iwaddr][8*i +: 8] = iwdata[8*i +: 8];
      end
    end
    if (run_mode && iclear) begin
      for (int i = 0; i < DP; i++) model[i] = '0;
      run_mode = 1'b0;
    end
    @(posedge clk);
    #1;
    got = qa.pop_front();
    checkOutput("a_valid", {31'b0, ra_valid}, {31'b0, got.valid});
    checkOutput("a_data", {16'h0000, ra_data}, got.data);
    got = qb.pop_front();
    checkOutput("b_valid", {31'b0, rb_valid}, {31'b0, got.valid});
    checkOutput("b_data", {16'h0000, rb_data}, got.data);
    clear = 1'b0;
    we    = 1'b0;
  endtask

  // Idle cycles through a sweep; ready must stay low until the n-th edge.
  task automatic sweepCheck(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      applyStimulus(1'b1, AW'(i % DP), 16'hA5A5, 2'b11, 1'b1, AW'(i % DP),
                    1'b0, '0, 1'b0);
      checkOutput(tag, {31'b0, ready}, {31'b0, (i == n)});
    end
    run_mode = 1'b1;
  endtask

  task automatic vStep(input logic iwe, input logic [VAW-1:0] iwaddr,
                       input logic [VDW-1:0] iwdata, input logic [VDW/8-1:0] iwmask,
                       input logic ren, input logic [VAW-1:0] raddr,
                       input logic exp_valid, input logic [31:0] exp_data,
                       input string tag);
    exp_t got;
    v_we = iwe; v_waddr = iwaddr; v_wdata = iwdata; v_wmask = iwmask;
    v_ra_en = ren; v_ra_addr = raddr;
    qv.push_back({exp_valid, exp_data});
    @(posedge clk);
    #1;
    got = qv.pop_front();
    checkOutput({tag, "_valid"}, {31'b0, v_ra_valid}, {31'b0, got.valid});
    checkOutput({tag, "_data"}, v_ra_data, got.data);
    v_we = 1'b0;
    v_ra_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wmask = '0;
    ra_en = 1'b0; ra_addr = '0; rb_en = 1'b0; rb_addr = '0;
    v_rst = 1'b1; v_clear = 1'b0; v_we = 1'b0; v_waddr = '0; v_wdata = '0;
    v_wmask = '0; v_ra_en = 1'b0; v_ra_addr = '0; v_rb_en = 1'b0; v_rb_addr = '0;
    run_mode = 1'b0; held_a = '0; held_b = '0;
    for (int i = 0; i < DP; i++) model[i] = '0;

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'b0, ready}, 32'd0);
    checkOutput("rst_a_valid", {31'b0, ra_valid}, 32'd0);
    checkOutput("rst_b_valid", {31'b0, rb_valid}, 32'd0);
    checkOutput("rst_a_data", {16'h0000, ra_data}, 32'd0);
    checkOutput("rst_b_data", {16'h0000, rb_data}, 32'd0);
    rst = 1'b0;

    $display("[TB] reset sweep");
    sweepCheck(DP, "sweep_ready");

    $display("[TB] read every address after sweep");
    for (int a = 0; a < DP; a++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, AW'(DP - 1 - a), 1'b0);
    end

    $display("[TB] masked write");
    applyStimulus(1'b1, 5'd5, 16'hBEEF, 2'b11, 1'b0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 5'd5, 16'h1234, 2'b10, 1'b0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd5, 1'b0, '0, 1'b0);
    checkOutput("masked_a", {16'h0000, ra_data}, 32'h0000_12EF);

    $display("[TB] forwarding on both ports");
    applyStimulus(1'b1, 5'd3, 16'h001A, 2'b11, 1'b0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 5'd3, 16'hFFFF, 2'b01, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0);
    checkOutput("fwd_a", {16'h0000, ra_data}, 32'h0000_00FF);
    checkOutput("fwd_b", {16'h0000, rb_data}, 32'h0000_00FF);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd5, 1'b0);

    $display("[TB] zero mask write is a no-op");
    applyStimulus(1'b1, 5'd7, 16'h5555, 2'b11, 1'b0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 5'd7, 16'hAAAA, 2'b00, 1'b1, 5'd7, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd31, 1'b0);

    $display("[TB] clear mid-run");
    applyStimulus(1'b1, 5'd10, 16'h0008, 2'b11, 1'b0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd10, 1'b1, 5'd5, 1'b0);
    applyStimulus(1'b1, 5'd11, 16'h7777, 2'b11, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1);
    sweepCheck(DP, "clear_ready");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd10, 1'b1, 5'd11, 1'b0);

    $display("[TB] reset during sweep");
    applyStimulus(1'b1, 5'd20, 16'hC3C3, 2'b11, 1'b1, 5'd20, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
      checkOutput("pre_rst_ready", {31'b0, ready}, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    held_a = '0;
    held_b = '0;
    checkOutput("midrst_ready", {31'b0, ready}, 32'd0);
    checkOutput("midrst_a_data", {16'h0000, ra_data}, 32'd0);
    sweepCheck(DP, "resweep_ready");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd20, 1'b1, 5'd0, 1'b0);

    $display("[TB] parameter variant");
    @(posedge clk);
    #1;
    v_rst = 1'b0;
    for (int i = 1; i <= VDP; i++) begin
      vStep(1'b0, '0, '0, '0, 1'b1, 4'd0, 1'b0, 32'd0, "v_sweep");
      checkOutput("v_ready", {31'b0, v_ready}, {31'b0, (i == VDP)});
    end
    vStep(1'b1, 4'd13, 32'hCAFE_F00D, 4'hF, 1'b0, '0, 1'b0, 32'd0, "v_wr13");
    vStep(1'b0, '0, '0, '0, 1'b1, 4'd13, 1'b1, 32'd0, "v_rd13");
    vStep(1'b1, 4'd11, 32'hDEAD_BEEF, 4'hF, 1'b0, '0, 1'b0, 32'd0, "v_wr11");
    vStep(1'b1, 4'd11, 32'h0000_0000, 4'b0101, 1'b1, 4'd11, 1'b1, 32'hDE00_BE00, "v_fwd11");
    vStep(1'b0, '0, '0, '0, 1'b1, 4'd11, 1'b1, 32'hDE00_BE00, "v_rd11");
    vStep(1'b0, '0, '0, '0, 1'b1, 4'd1, 1'b1, 32'd0, "v_rd1");
    vStep(1'b0, '0, '0, '0, 1'b1, 4'd12, 1'b1, 32'd0, "v_rd12");
    vStep(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 32'd0, "v_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
